// File: rtl/inv_softplus_8slice_pipelined.sv
// Inverse softplus x = ln(e^y - 1) on Q8.8 input, 8 chord segments, 3-stage valid/ready pipeline.
// Optional build macro INV_SOFTPLUS_ROUND_EN selects round-half-up on segment results (default: floor).
module inv_softplus_8slice_pipelined #(
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 16,
  parameter int FIXED_POINT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     domain_err,
  output logic [15:0]              err_count
);

  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {CLS_SEG, CLS_LOW, CLS_PASS, CLS_ERR} cls_t;

  localparam logic signed [DATA_W-1:0] BP [9] = '{
    16'sd16, 16'sd32, 16'sd64, 16'sd128, 16'sd256, 16'sd512, 16'sd768, 16'sd1024, 16'sd1536};
  localparam logic signed [COEF_W-1:0] SLOPE [8] = '{
    16'sd2969, 16'sd1552, 16'sd846, 16'sd499, 16'sd336, 16'sd280, 16'sd264, 16'sd258};
  localparam logic signed [DATA_W-1:0] INTERCEPT [8] = '{
    -16'sd887, -16'sd710, -16'sd534, -16'sd360, -16'sd198, -16'sd85, -16'sd38, -16'sd13};
  localparam logic signed [DATA_W-1:0] LOW_CLAMP = -16'sd702;
  localparam logic signed [DATA_W-1:0] ERR_OUT   = 16'sh8000;

  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(1 << (FIXED_POINT - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = -SAT_MAX - PROD_W'(1);

  function automatic logic signed [PROD_W-1:0] scale_prod(input logic signed [PROD_W-1:0] p);
`ifdef INV_SOFTPLUS_ROUND_EN
    return (p + HALF_LSB) >>> FIXED_POINT;
`else
    return p >>> FIXED_POINT;
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  logic advance;
  assign advance  = !valid_out || ready_out;
  assign ready_in = advance;

  // Stage 1: classify y and find its segment
  logic [2:0] idx_c;
  cls_t       cls_c;

  always_comb begin
    idx_c = '0;
    for (int k = 1; k < 8; k++)
      if (y_in >= BP[k]) idx_c = 3'(k);
    if (y_in[DATA_W-1] || (y_in == '0)) cls_c = CLS_ERR;
    else if (y_in < BP[0])              cls_c = CLS_LOW;
    else if (y_in >= BP[8])             cls_c = CLS_PASS;
    else                                cls_c = CLS_SEG;
  end

  logic                     vld_p0;
  logic signed [DATA_W-1:0] y_p0;
  logic [2:0]               idx_p0;
  cls_t                     cls_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      err_count <= '0;
    end else if (advance) begin
      vld_p0 <= valid_in;
      if (valid_in && (cls_c == CLS_ERR) && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      y_p0   <= y_in;
      idx_p0 <= idx_c;
      cls_p0 <= cls_c;
    end
  end

  // Stage 2: chord slope multiply
  logic signed [PROD_W-1:0] y_ext, slope_ext;
  assign y_ext     = {{COEF_W{y_p0[DATA_W-1]}}, y_p0};
  assign slope_ext = {{DATA_W{SLOPE[idx_p0][COEF_W-1]}}, SLOPE[idx_p0]};

  logic                     vld_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [DATA_W-1:0] y_p1;
  logic [2:0]               idx_p1;
  cls_t                     cls_p1;

  always_ff @(posedge clk) begin
    if (rst)          vld_p1 <= 1'b0;
    else if (advance) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      prod_p1 <= y_ext * slope_ext;
      y_p1    <= y_p0;
      idx_p1  <= idx_p0;
      cls_p1  <= cls_p0;
    end
  end

  // Stage 3: scale, add intercept, select by class
  logic signed [PROD_W-1:0] icpt_ext, seg_sum;
  logic signed [DATA_W-1:0] x_c;

  assign icpt_ext = {{COEF_W{INTERCEPT[idx_p1][DATA_W-1]}}, INTERCEPT[idx_p1]};
  assign seg_sum  = scale_prod(prod_p1) + icpt_ext;

  always_comb begin
    x_c = ERR_OUT;
    case (cls_p1)
      CLS_SEG:  x_c = sat_data(seg_sum);
      CLS_PASS: x_c = y_p1;
      CLS_LOW:  x_c = LOW_CLAMP;
      default:  x_c = ERR_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      x_out      <= '0;
      domain_err <= 1'b0;
    end else if (advance) begin
      valid_out  <= vld_p1;
      x_out      <= x_c;
      domain_err <= (cls_p1 == CLS_ERR);
    end
  end

endmodule

// File: tb/tb_inv_softplus_8slice_pipelined.sv
// Scoreboard bench for inv_softplus_8slice_pipelined: directed vectors, decoupled output monitor.
module tb_inv_softplus_8slice_pipelined;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] y_in;
  logic               valid_in;
  logic               ready_in;
  logic signed [15:0] x_out;
  logic               valid_out;
  logic               ready_out;
  logic               domain_err;
  logic [15:0]        err_count;

  always #5 clk = ~clk;

  inv_softplus_8slice_pipelined dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .x_out     (x_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .domain_err(domain_err),
    .err_count (err_count)
  );

  // Values that differ between floor and round-half-up builds
`ifdef INV_SOFTPLUS_ROUND_EN
  localparam logic signed [15:0] X_Y128  = -16'sd110;
  localparam logic signed [15:0] X_Y16   = -16'sd701;
  localparam logic signed [15:0] X_Y511  = 16'sd473;
  localparam logic signed [15:0] X_Y1535 = 16'sd1534;
`else
  localparam logic signed [15:0] X_Y128  = -16'sd111;
  localparam logic signed [15:0] X_Y16   = -16'sd702;
  localparam logic signed [15:0] X_Y511  = 16'sd472;
  localparam logic signed [15:0] X_Y1535 = 16'sd1533;
`endif
  localparam logic signed [15:0] X_ERR = 16'sh8000;

  typedef struct {
    logic signed [15:0] x;
    logic               derr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stall behaviour
  logic               prev_stall = 1'b0;
  logic signed [15:0] prev_x;
  logic               prev_d;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid_out", valid_out, 1);
        chk("hold_x_out", x_out, prev_x);
        chk("hold_domain_err", domain_err, prev_d);
      end
      if (valid_out && !ready_out) chk("stall_ready_in", ready_in, 0);
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d required=no_output", x_out);
        end else begin
          e = sb.pop_front();
          chk("x_out", x_out, e.x);
          chk("domain_err", domain_err, e.derr);
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_x     = x_out;
      prev_d     = domain_err;
    end
  end

  task automatic send(input logic signed [15:0] y, input logic signed [15:0] ex, input logic d);
    int n = 0;
    @(negedge clk);
    #1;
    valid_in = 1'b1;
    y_in     = y;
    while (!ready_in) begin
      if (n++ > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=ready_in_low required=accept y=%0d", y);
        valid_in = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    sb.push_back('{x: ex, derr: d});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    valid_in  = 1'b0;
    y_in      = '0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_domain_err", domain_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ready_in", ready_in, 1);
    @(negedge clk);
    rst = 1'b0;

    // y = 1.0
    send(16'sd256, 16'sd138, 1'b0);
    drain();

    // Back-to-back segment, pass and low-clamp
    send(16'sd128, X_Y128, 1'b0);
    send(16'sd1024, 16'sd1019, 1'b0);
    send(16'sd1536, 16'sd1536, 1'b0);
    send(16'sd8, -16'sd702, 1'b0);
    drain();

    // Domain errors
    send(-16'sd5, X_ERR, 1'b1);
    send(16'sd0, X_ERR, 1'b1);
    drain();
    chk("err_count_two", err_count, 2);

    // Stream with downstream stall after the first output
    fork
      begin
        send(16'sd256, 16'sd138, 1'b0);
        send(16'sd1024, 16'sd1019, 1'b0);
        send(16'sd512, 16'sd475, 1'b0);
        send(16'sd1536, 16'sd1536, 1'b0);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!valid_out && n < 40);
        ready_out = 1'b0;
        repeat (5) @(negedge clk);
        ready_out = 1'b1;
      end
    join
    drain();

    // Boundary sweep
    send(16'sd15, -16'sd702, 1'b0);
    send(16'sd16, X_Y16, 1'b0);
    send(16'sd511, X_Y511, 1'b0);
    send(16'sd512, 16'sd475, 1'b0);
    send(16'sd1535, X_Y1535, 1'b0);
    drain();

    // Reset with three samples held in flight
    @(negedge clk);
    ready_out = 1'b0;
    send(16'sd256, 16'sd138, 1'b0);
    send(16'sd1024, 16'sd1019, 1'b0);
    send(-16'sd3, X_ERR, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    ready_out = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_output", valid_out, 0);
    end

    // Latency after reset
    @(negedge clk);
    #1;
    valid_in = 1'b1;
    y_in     = 16'sd256;
    sb.push_back('{x: 16'sd138, derr: 1'b0});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    lat = 1;
    while (!valid_out && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
